// File: rtl/nibble_serial_adder.sv
`default_nettype none
// ============================================================================
//  Module      : nibble_serial_adder
//  Description : Nibble-serial adder/subtractor. An operand set is accepted
//                in IDLE. One 4-bit carry-lookahead slice is then processed
//                per clock, LSB nibble first. The result is presented with a
//                valid/ready handshake and held until the consumer takes it.
//  Revision    : 1.0  initial release
// ============================================================================
module nibble_serial_adder #(
    parameter int NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [4*NIBBLES-1:0]   A,
    input  logic [4*NIBBLES-1:0]   B,
    input  logic                   Cin,
    input  logic                   Sub,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [4*NIBBLES-1:0]   Sum,
    output logic                   Cout,
    output logic                   Ovf
);

    localparam int W  = 4 * NIBBLES;
    localparam int KW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    localparam logic [KW-1:0] K_LAST = KW'(NIBBLES - 1);
    localparam logic [KW-1:0] K_ONE  = KW'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [W-1:0]    a_q, a_d;
    logic [W-1:0]    b_q, b_d;      // holds ~B when subtracting
    logic            carry_q, carry_d;
    logic [KW-1:0]   k_q, k_d;
    logic [W-1:0]    sum_q, sum_d;
    logic            cout_q, cout_d;
    logic            ovf_q, ovf_d;

    // Nibble slice signals
    logic [KW+1:0]   w_base;
    logic [3:0]      w_a_nib;
    logic [3:0]      w_b_nib;
    logic [3:0]      w_g;
    logic [3:0]      w_p;
    logic [4:0]      w_c;           // w_c[0] is the incoming carry
    logic [3:0]      w_nib_sum;

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign Sum       = sum_q;
    assign Cout      = cout_q;
    assign Ovf       = ovf_q;

    // 4-bit carry-lookahead slice on the nibble currently selected by k
    always_comb begin
        w_base    = {k_q, 2'b00};
        w_a_nib   = a_q[w_base +: 4];
        w_b_nib   = b_q[w_base +: 4];
        w_g       = w_a_nib & w_b_nib;
        w_p       = w_a_nib ^ w_b_nib;
        w_c[0]    = carry_q;
        w_c[1]    = w_g[0] | (w_p[0] & carry_q);
        w_c[2]    = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & carry_q);
        w_c[3]    = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                  | (w_p[2] & w_p[1] & w_p[0] & carry_q);
        w_c[4]    = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                  | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                  | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & carry_q);
        w_nib_sum = w_p ^ w_c[3:0];
    end

    // Next-state and datapath update; inputs are only looked at in IDLE
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        k_d     = k_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = A;
                    b_d     = Sub ? ~B : B;
                    carry_d = Sub ? 1'b1 : Cin;
                    k_d     = '0;
                    state_d = ADD;
                end
            end
            ADD: begin
                sum_d[w_base +: 4] = w_nib_sum;
                carry_d            = w_c[4];
                k_d                = k_q + K_ONE;
                if (k_q == K_LAST) begin
                    cout_d  = w_c[4];
                    // carry into the MSB versus carry out of it
                    ovf_d   = w_c[3] ^ w_c[4];
                    k_d     = '0;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            k_q     <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            k_q     <= k_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_nibble_serial_adder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_nibble_serial_adder
//  Description : Directed self-checking bench for nibble_serial_adder.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_nibble_serial_adder;

    localparam int NIBBLES = 4;
    localparam int W       = 4 * NIBBLES;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  A;
    logic [W-1:0]  B;
    logic          Cin;
    logic          Sub;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  Sum;
    logic          Cout;
    logic          Ovf;

    int n_tests;
    int n_fail;

    nibble_serial_adder #(.NIBBLES(NIBBLES)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .Cin       (Cin),
        .Sub       (Sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Sum       (Sum),
        .Cout      (Cout),
        .Ovf       (Ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Called right after the accepting rising edge. Checks latency, result,
    // and that out_valid lasts one cycle when out_ready is already high.
    task automatic finish_op(input string tag, input logic [W-1:0] es,
                             input logic ec, input logic eo);
        int lat;
        @(negedge clk);
        in_valid = 1'b0;
        check({tag, "_busy_in_ready"}, {31'd0, in_ready}, 32'd0);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        check({tag, "_latency"}, lat, NIBBLES);
        check({tag, "_sum"},  {16'd0, Sum},  {16'd0, es});
        check({tag, "_cout"}, {31'd0, Cout}, {31'd0, ec});
        check({tag, "_ovf"},  {31'd0, Ovf},  {31'd0, eo});
        if (out_ready) begin
            @(negedge clk);
            check({tag, "_valid_one_cycle"}, {31'd0, out_valid}, 32'd0);
            check({tag, "_back_idle"},       {31'd0, in_ready},  32'd1);
        end
    endtask

    task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic cin, input logic sub,
                          input logic [W-1:0] es, input logic ec, input logic eo);
        @(negedge clk);
        A = a; B = b; Cin = cin; Sub = sub; in_valid = 1'b1;
        @(posedge clk);
        finish_op(tag, es, ec, eo);
    endtask

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        A = '0; B = '0; Cin = 1'b0; Sub = 1'b0;

        // Reset state, with no clock edge needed
        #1;
        check("rst_in_ready",  {31'd0, in_ready},  32'd1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_sum",       {16'd0, Sum},       32'd0);
        check("rst_cout",      {31'd0, Cout},      32'd0);
        check("rst_ovf",       {31'd0, Ovf},       32'd0);

        // Operand waiting during reset is taken on the first edge after release
        repeat (2) @(negedge clk);
        A = 16'h1234; B = 16'h4321; Cin = 1'b0; Sub = 1'b0; in_valid = 1'b1;
        rst_n = 1'b1;
        @(posedge clk);
        finish_op("basic_add", 16'h5555, 1'b0, 1'b0);

        run_op("carry_ripple", 16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
        run_op("signed_ovf",   16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
        run_op("sub_neg",      16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        run_op("sub_ovf",      16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
        run_op("cin_add",      16'hA5A5, 16'h1111, 1'b1, 1'b0, 16'hB6B7, 1'b0, 1'b0);

        // Backpressure: hold result while in_valid and A keep changing
        out_ready = 1'b0;
        run_op("bp", 16'h00F0, 16'h0F0F, 1'b0, 1'b0, 16'h0FFF, 1'b0, 1'b0);
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            A = 16'h1000 + 16'(i);
            @(posedge clk);
            @(negedge clk);
            check("bp_hold_sum",   {16'd0, Sum},       32'h0FFF);
            check("bp_hold_cout",  {31'd0, Cout},      32'd0);
            check("bp_hold_ovf",   {31'd0, Ovf},       32'd0);
            check("bp_valid",      {31'd0, out_valid}, 32'd1);
            check("bp_in_ready",   {31'd0, in_ready},  32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("bp_release_ready", {31'd0, in_ready},  32'd1);
        check("bp_release_valid", {31'd0, out_valid}, 32'd0);
        run_op("bp_next", 16'h0003, 16'h0004, 1'b0, 1'b0, 16'h0007, 1'b0, 1'b0);

        // Reset mid-ADD after two nibbles, asserted between clock edges
        @(negedge clk);
        A = 16'h1111; B = 16'h2222; Cin = 1'b0; Sub = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("mid_partial_sum", {16'd0, Sum}, 32'h0033);
        #1 rst_n = 1'b0;
        #1;
        check("mid_rst_sum",       {16'd0, Sum},       32'd0);
        check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("mid_rst_in_ready",  {31'd0, in_ready},  32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            @(negedge clk);
            check("post_rst_no_stale", {31'd0, out_valid}, 32'd0);
        end
        run_op("post_rst_add", 16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/nibble_serial_adder.md
NIBBLE_SERIAL_ADDER -- requirements
Module: nibble_serial_adder

Interface
REQ-001 The block SHALL have parameter NIBBLES, default 4, giving the number of 4-bit nibbles per operand (operand width W = 4*NIBBLES).
REQ-002 Port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-003 Port rst_n, input, 1: reset, asynchronous and active-low.
REQ-004 Port in_valid, input, 1: operand set valid.
REQ-005 Port in_ready, output, 1: block can accept an operand set.
REQ-006 Port A, input, W: operand A.
REQ-007 Port B, input, W: operand B.
REQ-008 Port Cin, input, 1: carry-in, used when Sub=0.
REQ-009 Port Sub, input, 1: 1 selects A-B, 0 selects A+B+Cin.
REQ-010 Port out_valid, output, 1: result valid.
REQ-011 Port out_ready, input, 1: consumer accepts the result.
REQ-012 Port Sum, output, W: result.
REQ-013 Port Cout, output, 1: carry out of the MSB (not-borrow when Sub=1).
REQ-014 Port Ovf, output, 1: two's-complement overflow.

Function
REQ-015 The block SHALL implement FSM states IDLE, ADD and DONE, with in_ready=1 only in IDLE and out_valid=1 only in DONE.
REQ-016 An accept SHALL occur on a rising edge with in_valid=1 and in_ready=1; A, B, Cin and Sub are captured, the nibble index is cleared to 0, and the state goes IDLE->ADD.
REQ-017 On capture, the operand register SHALL hold B'=~B with carry register=1 if Sub=1, else B'=B with carry register=Cin.
REQ-018 Each ADD cycle SHALL process nibble k with 4-bit carry-lookahead: G=A&B', P=A^B', internal carries c1..c4 from G/P and the carry register, and sum=P^carries.
REQ-019 Each ADD cycle SHALL write the 4-bit sum into Sum[4k+3:4k], load c4 into the carry register, and increment k.
REQ-020 On the ADD cycle with k=NIBBLES-1, the state SHALL go ADD->DONE, Cout SHALL be loaded with c4 of the last nibble, and Ovf SHALL be loaded with (carry into bit W-1) XOR (carry out of bit W-1).
REQ-021 out_valid SHALL rise exactly NIBBLES clock cycles after the accepting edge (4 cycles at default).
REQ-022 In DONE, Sum, Cout and Ovf SHALL hold stable until an edge with out_ready=1, which moves the state DONE->IDLE.
REQ-023 If out_ready is already 1 when DONE is entered, out_valid SHALL last exactly one cycle.
REQ-024 Operands SHALL NOT be accepted in ADD or DONE; in_valid and input changes SHALL be ignored there, giving a minimum spacing of NIBBLES+2 cycles between accepts.
REQ-025 Arithmetic SHALL be modulo 2^W; no nibble's sum may depend on a nibble processed later.
REQ-026 Sum bits not yet written in ADD SHALL keep their previous value, and SHALL NOT be relied on until out_valid=1.

Reset
REQ-027 While rst_n=0, the block SHALL be in IDLE with Sum=0, Cout=0, Ovf=0, out_valid=0, carry register=0, k=0 and in_ready=1, independent of clk.
REQ-028 Asserting rst_n in ADD or DONE SHALL abort the operation; the result SHALL be lost and never presented.
REQ-029 The first accept SHALL be possible on the first rising edge after rst_n deasserts.

Verification
REQ-030 Basic add with latency check: A=0x1234, B=0x4321, Cin=0, Sub=0 -> Sum=0x5555, Cout=0, Ovf=0, out_valid high 4 cycles after accept.
REQ-031 Full carry ripple: A=0xFFFF, B=0x0000, Cin=1 -> Sum=0x0000, Cout=1, Ovf=0.
REQ-032 Signed overflow: A=0x7FFF, B=0x0001, Cin=0 -> Sum=0x8000, Cout=0, Ovf=1.
REQ-033 Subtract: A=0x0005, B=0x0007, Sub=1, Cin=1 (ignored) -> Sum=0xFFFE, Cout=0, Ovf=0; and A=0x8000, B=0x0001, Sub=1 -> Sum=0x7FFF, Cout=1, Ovf=1.
REQ-034 Backpressure: hold out_ready=0 for 3 cycles in DONE with in_valid=1 and changing A -> Sum, Cout and Ovf stable, in_ready=0, no accept; raise out_ready -> IDLE, in_ready=1 the next cycle, new operand accepted.
REQ-035 Reset mid-ADD: pull rst_n low between clock edges after 2 nibbles -> Sum=0, out_valid=0, in_ready=1 immediately; after release, A=0x0001, B=0x0001 -> Sum=0x0002 with no stale result presented.
